// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one single-port RAM between
// NUM_REQ requesters, with a single access in flight at a time.
// Each access moves through IDLE -> ISSUE -> (WAIT for reads) -> DONE.
// Optional feature macro: ARB_LOCK_EN adds a lock input. While lock is high,
// only the highest-numbered requester may win arbitration.
module mem_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int RAM_LAT = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          done,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
`ifdef ARB_LOCK_EN
    input  logic                        lock,
`endif
    output logic                        busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                found_hi, found_lo, found;
    logic [IDX_W-1:0]    pick_hi, pick_lo, pick;

    // Requests allowed to compete this cycle; lock narrows the field to the top requester.
    always_comb begin
        eligible = req;
`ifdef ARB_LOCK_EN
        if (lock) begin
            eligible = '0;
            eligible[NUM_REQ-1] = req[NUM_REQ-1];
        end
`endif
    end

    // Round-robin pick: lowest eligible index above last, otherwise lowest eligible overall (wrap).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found_hi && eligible[j] && (j > int'(last_q))) begin
                found_hi = 1'b1;
                pick_hi  = IDX_W'(j);
            end
            if (!found_lo && eligible[j]) begin
                found_lo = 1'b1;
                pick_lo  = IDX_W'(j);
            end
        end
        found = found_hi | found_lo;
        pick  = found_hi ? pick_hi : pick_lo;
    end

    // Next-state and output decode for the access sequencer.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        last_d  = last_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        gnt     = '0;
        done    = '0;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    last_d  = pick;
                    we_d    = req_we[pick];
                    addr_d  = req_addr[int'(pick)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[int'(pick)*DATA_W +: DATA_W];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                mem_en     = 1'b1;
                mem_we     = we_q;
                gnt[win_q] = 1'b1;
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(RAM_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The counter reaches zero in the cycle the RAM data becomes valid.
                if (cnt_q == '0) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                done[win_q] = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latch registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a two-cycle
// latency RAM model. Compile with ARB_LOCK_EN defined to include the lock steps.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  req_we;
    logic [47:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic [7:0]  rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        lock;

    mem_port_arbiter #(.NUM_REQ(3), .ADDR_W(16), .DATA_W(8), .RAM_LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM model: 256 bytes indexed by addr[7:0], read data valid two cycles after mem_en.
    logic [7:0] ram [0:255];
    logic [7:0] rd1, rd2;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 3);
        end else if (mem_en && mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
        rd1 <= ram[mem_addr[7:0]];
        rd2 <= rd1;
    end
    assign mem_rdata = rd2;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int g_idx[$], g_cyc[$], d_idx[$], d_cyc[$];
    logic [7:0]  d_rdata[$];
    logic        iss_we;
    logic [15:0] iss_addr;
    logic [7:0]  iss_wdata;
    int en_cnt, we_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [2:0] v);
        if ($countones(v) != 1) return 99;
        for (int i = 0; i < 3; i++) if (v[i]) return i;
        return 99;
    endfunction

    task automatic clear_logs();
        g_idx.delete(); g_cyc.delete(); d_idx.delete(); d_cyc.delete(); d_rdata.delete();
        en_cnt = 0; we_cnt = 0;
    endtask

    // Advance one clock, then observe outputs 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (mem_en) en_cnt++;
        if (mem_we) we_cnt++;
        if (gnt != 3'b000) begin
            g_idx.push_back(oh_idx(gnt)); g_cyc.push_back(cyc);
            iss_we = mem_we; iss_addr = mem_addr; iss_wdata = mem_wdata;
        end
        if (done != 3'b000) begin
            d_idx.push_back(oh_idx(done)); d_cyc.push_back(cyc); d_rdata.push_back(rdata);
        end
    endtask

    task automatic tick_until_gnts(input int n, input int budget);
        for (int k = 0; k < budget && g_idx.size() < n; k++) tick();
    endtask

    task automatic tick_until_dones(input int n, input int budget);
        for (int k = 0; k < budget && d_idx.size() < n; k++) tick();
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 30 && busy; k++) tick();
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_rd[3];
        logic [7:0] rd_before;
        int order[4];
        int base;
        logic seen2;
        exp_rd[0] = 8'h03; exp_rd[1] = 8'h0A; exp_rd[2] = 8'h11;
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 0;
        reset = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; lock = 1'b0;
        clear_logs();
        tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_rdata", 32'(rdata), 0);

        // Three simultaneous reads: order 0,1,2,0; done 3 after gnt; gnt spacing 5.
        clear_logs();
        req_addr = {16'h0302, 16'h0201, 16'h0100};
        req = 3'b111;
        tick_until_gnts(4, 60);
        req = 3'b000;
        check("rr_gnt_count", 32'(g_idx.size()), 4);
        tick_until_dones(4, 20);
        check("rr_done_count", 32'(d_idx.size()), 4);
        for (int i = 0; i < 4 && i < g_idx.size() && i < d_idx.size(); i++) begin
            $display("rr txn %0d: gnt %0d @%0d done %0d @%0d rdata %0h", i, g_idx[i], g_cyc[i], d_idx[i], d_cyc[i], d_rdata[i]);
            check($sformatf("rr_gnt_order%0d", i), 32'(g_idx[i]), 32'(order[i]));
            check($sformatf("rr_done_idx%0d", i), 32'(d_idx[i]), 32'(order[i]));
            check($sformatf("rr_done_lat%0d", i), 32'(d_cyc[i] - g_cyc[i]), 3);
            check($sformatf("rr_rdata%0d", i), 32'(d_rdata[i]), 32'(exp_rd[order[i]]));
            if (i > 0) check($sformatf("rr_spacing%0d", i), 32'(g_cyc[i] - g_cyc[i-1]), 5);
        end
        wait_idle("rr_idle");

        // Write from requester 1: one issue cycle, done next cycle, rdata untouched.
        rd_before = rdata;
        clear_logs();
        req_addr = {16'h0000, 16'h0010, 16'h0000};
        req_wdata = {8'h00, 8'hA5, 8'h00};
        req_we = 3'b010;
        req = 3'b010;
        tick_until_gnts(1, 20);
        req = 3'b000;
        tick_until_dones(1, 20);
        $display("wr txn: gnt %0d mem_we %0b addr %0h wdata %0h done %0d", g_idx.size() > 0 ? g_idx[0] : -1, iss_we, iss_addr, iss_wdata, d_idx.size() > 0 ? d_idx[0] : -1);
        check("wr_gnt_count", 32'(g_idx.size()), 1);
        check("wr_done_count", 32'(d_idx.size()), 1);
        if (g_idx.size() == 1 && d_idx.size() == 1) begin
            check("wr_gnt_idx", 32'(g_idx[0]), 1);
            check("wr_mem_we", 32'(iss_we), 1);
            check("wr_mem_addr", 32'(iss_addr), 32'h0010);
            check("wr_mem_wdata", 32'(iss_wdata), 32'hA5);
            check("wr_done_idx", 32'(d_idx[0]), 1);
            check("wr_done_lat", 32'(d_cyc[0] - g_cyc[0]), 1);
            check("wr_rdata_kept", 32'(d_rdata[0]), 32'(rd_before));
        end
        check("wr_en_cycles", 32'(en_cnt), 1);
        wait_idle("wr_idle");

        // Read back from requester 0.
        clear_logs();
        req_we = 3'b000;
        req_addr = {16'h0000, 16'h0000, 16'h0010};
        req = 3'b001;
        tick_until_gnts(1, 20);
        req = 3'b000;
        tick_until_dones(1, 20);
        check("rd_done_count", 32'(d_idx.size()), 1);
        if (g_idx.size() == 1 && d_idx.size() == 1) begin
            $display("rd txn: gnt %0d @%0d done %0d @%0d rdata %0h", g_idx[0], g_cyc[0], d_idx[0], d_cyc[0], d_rdata[0]);
            check("rd_gnt_idx", 32'(g_idx[0]), 0);
            check("rd_done_lat", 32'(d_cyc[0] - g_cyc[0]), 3);
            check("rd_rdata", 32'(d_rdata[0]), 32'hA5);
        end
        check("rd_mem_we_low", 32'(we_cnt), 0);
        wait_idle("rd_idle");

        // Reset during WAIT of a requester 2 read.
        clear_logs();
        req_addr = {16'h0302, 16'h0000, 16'h0100};
        req = 3'b100;
        tick_until_gnts(1, 20);
        req = 3'b000;
        check("rstw_gnt_count", 32'(g_idx.size()), 1);
        tick();
        reset = 1'b1;
        tick();
        $display("reset in WAIT: busy %0b gnt %0b done %0b mem_en %0b", busy, gnt, done, mem_en);
        check("rstw_busy", 32'(busy), 0);
        check("rstw_gnt", 32'(gnt), 0);
        check("rstw_done", 32'(done), 0);
        check("rstw_mem_en", 32'(mem_en), 0);
        tick();
        reset = 1'b0;
        tick(); tick(); tick();
        check("rstw_no_done", 32'(d_idx.size()), 0);
        clear_logs();
        req = 3'b101;
        tick_until_gnts(1, 20);
        req = 3'b000;
        check("rstw_after_gnt_count", 32'(g_idx.size()), 1);
        if (g_idx.size() == 1) check("rstw_after_gnt_idx", 32'(g_idx[0]), 0);
        tick_until_dones(1, 20);
        check("rstw_after_done_count", 32'(d_idx.size()), 1);
        if (d_idx.size() == 1) check("rstw_after_done_idx", 32'(d_idx[0]), 0);
        wait_idle("rstw_idle");

        // Fairness: requester 0 holds req; requester 2 must win within two grants.
        clear_logs();
        req = 3'b001;
        tick_until_gnts(2, 40);
        check("fair_pre_gnts", 32'(g_idx.size()), 2);
        req = 3'b101;
        base = g_idx.size();
        tick_until_gnts(base + 2, 40);
        req = 3'b000;
        seen2 = 1'b0;
        for (int i = base; i < g_idx.size() && i < base + 2; i++) if (g_idx[i] == 2) seen2 = 1'b1;
        $display("fairness: grants after raise %0d, req2 served %0b", g_idx.size() - base, seen2);
        check("fair_gnt2_within2", 32'(seen2), 1);
        wait_idle("fair_idle");

`ifdef ARB_LOCK_EN
        // Lock: only requester 2 wins; releasing lock resumes at requester 0.
        clear_logs();
        lock = 1'b1;
        req = 3'b111;
        tick_until_gnts(4, 60);
        lock = 1'b0;
        check("lock_gnt_count", 32'(g_idx.size()), 4);
        for (int i = 0; i < 4 && i < g_idx.size(); i++)
            check($sformatf("lock_gnt%0d", i), 32'(g_idx[i]), 2);
        tick_until_gnts(5, 30);
        req = 3'b000;
        check("unlock_gnt_count", 32'(g_idx.size()), 5);
        if (g_idx.size() == 5) check("unlock_gnt_idx", 32'(g_idx[4]), 0);
        $display("lock: %0d grants total after unlock", g_idx.size());
        wait_idle("lock_idle");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
